// File: rtl/seven_segment_pkg.sv
// Shared definitions for the 7-segment capture path: active-low segment patterns
// (identical to the encoder's table) and the capture FSM state type.
package seven_segment_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HOLD   = 2'd2
   } cap_state_e;

endpackage

// File: rtl/seven_segment_capture_if.sv
// Multiplexed display bus plus the decoded read-back results of the capture block.
interface seven_segment_capture_if #(
   parameter int NUM_DIGITS = 8,
   parameter int ERR_CNT_W  = 8
);
   logic [6:0]              seg_in;
   logic [NUM_DIGITS-1:0]   dig_sel_n;
   logic                    clear;
   logic [4*NUM_DIGITS-1:0] value_out;
   logic [NUM_DIGITS-1:0]   digit_valid;
   logic                    frame_valid;
   logic                    pattern_error;
   logic [ERR_CNT_W-1:0]    err_count;

   modport master (
      output seg_in, dig_sel_n, clear,
      input  value_out, digit_valid, frame_valid, pattern_error, err_count
   );

   modport slave (
      input  seg_in, dig_sel_n, clear,
      output value_out, digit_valid, frame_valid, pattern_error, err_count
   );
endinterface

// File: rtl/seven_segment_pattern_decoder.sv
// Inverse of the hex-to-segment encoder: classifies a 7-bit active-low pattern
// as a hex digit, a blank, or neither.
module seven_segment_pattern_decoder
   import seven_segment_pkg::*;
(
   input  logic [6:0] pattern_i,
   output logic       is_hex_o,
   output logic       is_blank_o,
   output logic [3:0] nibble_o
);

   // Table lookup; anything outside the encoder's 16 codes and blank is illegal
   always_comb begin
      is_hex_o   = 1'b1;
      is_blank_o = 1'b0;
      nibble_o   = 4'h0;
      case (pattern_i)
         SEG_0:     nibble_o = 4'h0;
         SEG_1:     nibble_o = 4'h1;
         SEG_2:     nibble_o = 4'h2;
         SEG_3:     nibble_o = 4'h3;
         SEG_4:     nibble_o = 4'h4;
         SEG_5:     nibble_o = 4'h5;
         SEG_6:     nibble_o = 4'h6;
         SEG_7:     nibble_o = 4'h7;
         SEG_8:     nibble_o = 4'h8;
         SEG_9:     nibble_o = 4'h9;
         SEG_A:     nibble_o = 4'hA;
         SEG_B:     nibble_o = 4'hB;
         SEG_C:     nibble_o = 4'hC;
         SEG_D:     nibble_o = 4'hD;
         SEG_E:     nibble_o = 4'hE;
         SEG_F:     nibble_o = 4'hF;
         SEG_BLANK: begin
            is_hex_o   = 1'b0;
            is_blank_o = 1'b1;
         end
         default:   is_hex_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/seven_segment_capture.sv
// Samples a multiplexed active-low 7-segment bus, debounces each digit dwell and
// reassembles the displayed hex value one complete scan (frame) at a time.
module seven_segment_capture
   import seven_segment_pkg::*;
#(
   parameter int NUM_DIGITS    = 8,
   parameter int STABLE_CYCLES = 4,
   parameter int ERR_CNT_W     = 8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   seven_segment_capture_if.slave bus
);

   localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0]     CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0]     CNT_ACCEPT = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [ERR_CNT_W-1:0] ERR_MAX    = {ERR_CNT_W{1'b1}};

   logic [6:0]                  seg_q;
   logic [NUM_DIGITS-1:0]       sel_q;
   cap_state_e                  state_q;
   logic [CNT_W-1:0]            cnt_q;
   logic [6:0]                  cand_seg_q;
   logic [NUM_DIGITS-1:0]       cand_sel_q;
   logic [NUM_DIGITS-1:0][3:0]  shadow_q;
   logic [NUM_DIGITS-1:0]       shadow_ok_q;
   logic [NUM_DIGITS-1:0]       seen_q;
   logic [NUM_DIGITS-1:0]       seen_d;
   logic [4*NUM_DIGITS-1:0]     value_out_q;
   logic [NUM_DIGITS-1:0]       digit_valid_q;
   logic                        frame_valid_q;
   logic                        pattern_error_q;
   logic [ERR_CNT_W-1:0]        err_count_q;
   logic [ERR_CNT_W-1:0]        err_count_d;

   logic                        sel_legal_s;
   logic                        match_s;
   logic                        accept_s;
   logic                        bad_s;
   logic                        frame_done_s;
   logic [IDX_W-1:0]            idx_s;
   logic                        dec_hex_s;
   logic                        dec_blank_s;
   logic [3:0]                  dec_nib_s;

   // Input stage: the bus is synchronous to clk, one register decouples routing
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         seg_q <= SEG_BLANK;
         sel_q <= {NUM_DIGITS{1'b1}};
      end else begin
         seg_q <= bus.seg_in;
         sel_q <= bus.dig_sel_n;
      end
   end

   seven_segment_pattern_decoder u_decoder (
      .pattern_i  (seg_q),
      .is_hex_o   (dec_hex_s),
      .is_blank_o (dec_blank_s),
      .nibble_o   (dec_nib_s)
   );

   assign sel_legal_s  = $onehot(~sel_q);
   assign match_s      = (seg_q == cand_seg_q) && (sel_q == cand_sel_q);
   assign accept_s     = (state_q == ST_SETTLE) && match_s && (cnt_q == CNT_ACCEPT);
   assign bad_s        = accept_s && !dec_hex_s && !dec_blank_s;
   assign frame_done_s = &seen_q;
   assign seen_d       = (frame_done_s ? {NUM_DIGITS{1'b0}} : seen_q)
                       | ({NUM_DIGITS{accept_s}} & ~sel_q);

   // Index of the single low select bit (only meaningful for a legal select)
   always_comb begin
      idx_s = {IDX_W{1'b0}};
      for (int i = 0; i < NUM_DIGITS; i++) begin
         idx_s = sel_q[i] ? idx_s : IDX_W'(i);
      end
   end

   // Saturating error count
   always_comb begin
      if (bad_s && (err_count_q != ERR_MAX)) begin
         err_count_d = err_count_q + ERR_CNT_W'(1);
      end else begin
         err_count_d = err_count_q;
      end
   end

   // Dwell FSM: a sample must repeat STABLE_CYCLES times before it is accepted once
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= {CNT_W{1'b0}};
         cand_seg_q <= 7'h00;
         cand_sel_q <= {NUM_DIGITS{1'b0}};
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (sel_legal_s) begin
                  state_q    <= ST_SETTLE;
                  cnt_q      <= CNT_ONE;
                  cand_seg_q <= seg_q;
                  cand_sel_q <= sel_q;
               end
            end
            ST_SETTLE, ST_HOLD: begin
               if (match_s) begin
                  if (state_q == ST_SETTLE) begin
                     if (cnt_q == CNT_ACCEPT) begin
                        state_q <= ST_HOLD;
                     end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                     end
                  end
               end else if (sel_legal_s) begin
                  state_q    <= ST_SETTLE;
                  cnt_q      <= CNT_ONE;
                  cand_seg_q <= seg_q;
                  cand_sel_q <= sel_q;
               end else begin
                  state_q <= ST_IDLE;
                  cnt_q   <= {CNT_W{1'b0}};
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= {CNT_W{1'b0}};
            end
         endcase
      end
   end

   // Shadow frame assembly and registered outputs; clear wins over completion
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shadow_q        <= '0;
         shadow_ok_q     <= {NUM_DIGITS{1'b0}};
         seen_q          <= {NUM_DIGITS{1'b0}};
         value_out_q     <= {(4*NUM_DIGITS){1'b0}};
         digit_valid_q   <= {NUM_DIGITS{1'b0}};
         frame_valid_q   <= 1'b0;
         pattern_error_q <= 1'b0;
         err_count_q     <= {ERR_CNT_W{1'b0}};
      end else if (bus.clear) begin
         shadow_q        <= '0;
         shadow_ok_q     <= {NUM_DIGITS{1'b0}};
         seen_q          <= {NUM_DIGITS{1'b0}};
         digit_valid_q   <= {NUM_DIGITS{1'b0}};
         frame_valid_q   <= 1'b0;
         pattern_error_q <= 1'b0;
         err_count_q     <= {ERR_CNT_W{1'b0}};
      end else begin
         frame_valid_q   <= frame_done_s;
         pattern_error_q <= bad_s;
         err_count_q     <= err_count_d;
         seen_q          <= seen_d;
         if (frame_done_s) begin
            value_out_q   <= shadow_q;
            digit_valid_q <= shadow_ok_q;
         end
         if (accept_s) begin
            shadow_q[idx_s]    <= dec_hex_s ? dec_nib_s : 4'h0;
            shadow_ok_q[idx_s] <= dec_hex_s;
         end
      end
   end

   assign bus.value_out     = value_out_q;
   assign bus.digit_valid   = digit_valid_q;
   assign bus.frame_valid   = frame_valid_q;
   assign bus.pattern_error = pattern_error_q;
   assign bus.err_count     = err_count_q;

endmodule

// File: tb/tb_seven_segment_capture.sv
// Bench for seven_segment_capture: directed scenarios plus random bus traffic,
// checked every cycle against a run-length model of the display bus.
module tb_seven_segment_capture;

   localparam int ND = 8;
   localparam int S  = 4;
   localparam int EW = 8;
   localparam int ERR_SAT = (1 << EW) - 1;
   localparam logic [6:0] ENC [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   fv_cnt = 0;
   int   pe_cnt = 0;

   seven_segment_capture_if #(.NUM_DIGITS(ND), .ERR_CNT_W(EW)) bus ();

   seven_segment_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(S), .ERR_CNT_W(EW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference model state
   int          m_nib [ND];
   bit          m_ok [ND];
   bit [ND-1:0] m_seen;
   bit [4*ND-1:0] m_value;
   bit [ND-1:0] m_valid;
   bit          m_fv, m_pe;
   int          m_err;
   logic [6:0]  run_seg;
   logic [ND-1:0] run_sel;
   int          run_len;
   bit          pend;
   logic [6:0]  pend_seg;
   int          pend_dig;

   function automatic int low_idx(logic [ND-1:0] s);
      int n = 0;
      int idx = -1;
      for (int i = 0; i < ND; i++) begin
         if (s[i] === 1'b0) begin n++; idx = i; end
      end
      return (n == 1) ? idx : -1;
   endfunction

   // 0..15 hex digit, 16 blank, -1 illegal
   function automatic int decode(logic [6:0] p);
      for (int i = 0; i < 16; i++) if (ENC[i] == p) return i;
      if (p == 7'h7F) return 16;
      return -1;
   endfunction

   // Model: a bus value held for S consecutive edges with a legal select is accepted on the next edge
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < ND; i++) begin m_nib[i] = 0; m_ok[i] = 1'b0; end
         m_seen = '0; m_value = '0; m_valid = '0; m_fv = 1'b0; m_pe = 1'b0; m_err = 0;
         run_len = 0; pend = 1'b0;
      end else begin
         m_fv = 1'b0;
         m_pe = 1'b0;
         if (bus.clear) begin
            for (int i = 0; i < ND; i++) begin m_nib[i] = 0; m_ok[i] = 1'b0; end
            m_seen = '0; m_valid = '0; m_err = 0;
         end else begin
            if (m_seen == {ND{1'b1}}) begin
               for (int i = 0; i < ND; i++) begin
                  m_value[4*i +: 4] = 4'(m_nib[i]);
                  m_valid[i] = m_ok[i];
               end
               m_fv = 1'b1;
               m_seen = '0;
            end
            if (pend) begin
               int d;
               d = decode(pend_seg);
               m_nib[pend_dig] = (d >= 0 && d < 16) ? d : 0;
               m_ok[pend_dig]  = (d >= 0 && d < 16);
               m_seen[pend_dig] = 1'b1;
               if (d < 0) begin
                  m_pe = 1'b1;
                  if (m_err < ERR_SAT) m_err++;
               end
            end
         end
         pend = 1'b0;
         if (run_len > 0 && bus.seg_in === run_seg && bus.dig_sel_n === run_sel) begin
            run_len++;
         end else begin
            run_seg = bus.seg_in;
            run_sel = bus.dig_sel_n;
            run_len = 1;
         end
         if (run_len == S && low_idx(run_sel) >= 0) begin
            pend = 1'b1;
            pend_seg = run_seg;
            pend_dig = low_idx(run_sel);
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle compare against the model, away from the active edge
   always @(negedge clk) begin
      chk("value_out", 64'(bus.value_out), 64'(m_value));
      chk("digit_valid", 64'(bus.digit_valid), 64'(m_valid));
      chk("frame_valid", 64'(bus.frame_valid), 64'(m_fv));
      chk("pattern_error", 64'(bus.pattern_error), 64'(m_pe));
      chk("err_count", 64'(bus.err_count), 64'(m_err));
      if (bus.frame_valid === 1'b1) fv_cnt++;
      if (bus.pattern_error === 1'b1) pe_cnt++;
   end

   task automatic dwell(input int dig, input logic [6:0] seg, input int n);
      bus.dig_sel_n = ~(ND'(1) << dig);
      bus.seg_in    = seg;
      repeat (n) @(negedge clk);
   endtask

   task automatic blank(input int n);
      bus.dig_sel_n = {ND{1'b1}};
      bus.seg_in    = 7'h7F;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_clear();
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
   endtask

   task automatic scan(input logic [3:0] v [ND]);
      for (int i = 0; i < ND; i++) dwell(i, ENC[v[i]], 10);
      blank(4);
   endtask

   initial begin
      logic [3:0] vals [ND];
      int f0, p0;
      bus.seg_in = 7'h7F;
      bus.dig_sel_n = {ND{1'b1}};
      bus.clear = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset value_out", 64'(bus.value_out), 64'd0);
      chk("reset err_count", 64'(bus.err_count), 64'd0);
      chk("reset digit_valid", 64'(bus.digit_valid), 64'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // 1: plain scan of 1..8
      f0 = fv_cnt;
      vals = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
      scan(vals);
      chk("t1 frames", 64'(fv_cnt - f0), 64'd1);
      chk("t1 value", 64'(bus.value_out), 64'h87654321);
      chk("t1 model value", 64'(m_value), 64'h87654321);
      chk("t1 valid", 64'(bus.digit_valid), 64'hFF);
      chk("t1 err", 64'(bus.err_count), 64'd0);

      // 2: short glitch on digit 0 must not be accepted
      do_clear();
      dwell(0, 7'h40, 3);
      dwell(0, 7'h79, 10);
      for (int i = 1; i < ND; i++) dwell(i, ENC[8 + i], 10);
      blank(4);
      chk("t2 value", 64'(bus.value_out), 64'hFEDCBA91);
      chk("t2 err", 64'(bus.err_count), 64'd0);

      // 3: illegal pattern on digit 3, blank on digit 4
      do_clear();
      p0 = pe_cnt;
      for (int i = 0; i < ND; i++) begin
         if (i == 3) dwell(i, 7'h55, 10);
         else if (i == 4) dwell(i, 7'h7F, 10);
         else dwell(i, ENC[i], 10);
      end
      blank(4);
      chk("t3 value", 64'(bus.value_out), 64'h76500210);
      chk("t3 valid", 64'(bus.digit_valid), 64'hE7);
      chk("t3 err", 64'(bus.err_count), 64'd1);
      chk("t3 pe pulses", 64'(pe_cnt - p0), 64'd1);

      // 4: two selects low for 20 cycles between partial scans
      do_clear();
      f0 = fv_cnt;
      for (int i = 0; i < 6; i++) dwell(i, ENC[12 + (i % 4) - ((i >= 4) ? 2 : 0)], 10);
      bus.dig_sel_n = 8'hFC;
      bus.seg_in = 7'h40;
      repeat (20) @(negedge clk);
      chk("t4 no early frame", 64'(fv_cnt - f0), 64'd0);
      dwell(6, ENC[3], 10);
      dwell(7, ENC[4], 10);
      blank(4);
      chk("t4 frames", 64'(fv_cnt - f0), 64'd1);
      chk("t4 value", 64'(bus.value_out), 64'h43BAFEDC);
      chk("t4 err", 64'(bus.err_count), 64'd0);

      // 5: reset after five digits, then a full rescan
      f0 = fv_cnt;
      for (int i = 0; i < 5; i++) dwell(i, ENC[9], 10);
      bus.dig_sel_n = ~(ND'(1) << 5);
      bus.seg_in = ENC[9];
      repeat (2) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("t5 value in reset", 64'(bus.value_out), 64'd0);
      chk("t5 valid in reset", 64'(bus.digit_valid), 64'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      chk("t5 no frame", 64'(fv_cnt - f0), 64'd0);
      vals = '{4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
      scan(vals);
      chk("t5 frames", 64'(fv_cnt - f0), 64'd1);
      chk("t5 value", 64'(bus.value_out), 64'h12345678);

      // 6: error counter saturation, then clear
      for (int k = 0; k < 300; k++) dwell(k % 2, 7'h55, 5);
      blank(4);
      chk("t6 err sat", 64'(bus.err_count), 64'd255);
      do_clear();
      @(negedge clk);
      chk("t6 err cleared", 64'(bus.err_count), 64'd0);
      chk("t6 valid cleared", 64'(bus.digit_valid), 64'd0);
      chk("t6 value held", 64'(bus.value_out), 64'h12345678);

      // Random bus traffic against the model
      for (int k = 0; k < 400; k++) begin
         int r, r2, n;
         r  = int'($urandom_range(0, 9));
         r2 = int'($urandom_range(0, 19));
         n  = int'($urandom_range(1, 8));
         if (r < ND) bus.dig_sel_n = ~(ND'(1) << r);
         else if (r == ND) bus.dig_sel_n = {ND{1'b1}};
         else bus.dig_sel_n = ND'($urandom);
         if (r2 < 16) bus.seg_in = ENC[r2];
         else if (r2 == 16) bus.seg_in = 7'h7F;
         else bus.seg_in = 7'($urandom);
         bus.clear = ($urandom_range(0, 49) == 0);
         @(negedge clk);
         bus.clear = 1'b0;
         repeat (n - 1) @(negedge clk);
      end
      blank(6);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
